wb_project_router: RTL

- Wishbone slave front end that owns the user-area bus window.
- Decodes each bus access to one of NUM_SLOTS 0x100-byte project register windows and forwards it as a per-slot strobe.
- Waits for the slot's ack, and generates a timeout ack if the slot never answers, so a dead or unselected project cannot hang the bus.
- Also holds the active-project register and sequences safe project switchover: holds the project in reset and parks the IO pads for a fixed time.

---
 rtl/wb_project_router.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/wb_project_router.sv
// Wishbone front end for the user-area window: decodes per-project register slots, times out
// silent slots, and owns the active-project register with a reset/pad-park switchover sequence.
module wb_project_router #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned NUM_SLOTS   = 8,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned SWITCH_HOLD = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic [NUM_SLOTS-1:0]      slot_stb_o,
  input  logic [NUM_SLOTS-1:0]      slot_ack_i,
  input  logic [NUM_SLOTS*32-1:0]   slot_dat_i,
  output logic [7:0]                active_project_o,
  output logic                      project_reset_o,
  output logic                      io_park_o
);

  localparam int unsigned SlotW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [31:0] WinSize  = 32'(NUM_SLOTS * 256);
  localparam logic [7:0]  ToLast   = 8'(TIMEOUT - 1);
  localparam logic [7:0]  HoldInit = 8'(SWITCH_HOLD);

  typedef enum logic [1:0] {StIdle, StWait, StResp} bus_state_e;
  typedef enum logic {StRun, StHold} seq_state_e;

  bus_state_e           bus_state_q, bus_state_d;
  seq_state_e           seq_state_q, seq_state_d;
  logic [SlotW-1:0]     slot_q, slot_d;
  logic [7:0]           wait_cnt_q, wait_cnt_d;
  logic [NUM_SLOTS-1:0] stb_vec_q, stb_vec_d;
  logic                 skip_q, ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic [7:0]           to_count_q, to_count_d;
  logic [7:0]           last_to_slot_q, last_to_slot_d;
  logic [7:0]           active_q, active_d;
  logic [7:0]           hold_cnt_q, hold_cnt_d;

  logic             valid, accept, in_range, is_local, active_wr;
  logic             strobing, slot_ack_sel, timed_out;
  logic [31:0]      offset, slot_rdata, status;
  logic [SlotW-1:0] adr_slot;
  logic             unused_bits;

  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8]};

  // Wrapping subtraction folds the below-base case into the single range compare.
  assign offset    = wbs_adr_i - BASE_ADDR;
  assign in_range  = offset < WinSize;
  assign adr_slot  = offset[8 +: SlotW];
  assign valid     = wbs_cyc_i & wbs_stb_i;
  assign accept    = (bus_state_q == StIdle) & valid & ~skip_q;
  assign is_local  = in_range & (adr_slot == '0);
  assign active_wr = accept & is_local & wbs_we_i & wbs_sel_i[0] & (offset[7:0] == 8'h00);

  assign strobing     = |stb_vec_q;
  assign slot_ack_sel = slot_ack_i[slot_q];
  assign slot_rdata   = slot_dat_i[32*int'(slot_q) +: 32];
  assign timed_out    = (bus_state_q == StWait) & strobing & ~slot_ack_sel & (wait_cnt_q == ToLast);
  assign status       = {15'b0, seq_state_q == StHold, last_to_slot_q, to_count_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_state_q    <= StIdle;
      slot_q         <= '0;
      wait_cnt_q     <= '0;
      stb_vec_q      <= '0;
      skip_q         <= 1'b0;
      ack_q          <= 1'b0;
      dat_q          <= '0;
      to_count_q     <= '0;
      last_to_slot_q <= '0;
      active_q       <= '0;
      seq_state_q    <= StHold;
      hold_cnt_q     <= HoldInit;
    end else begin
      bus_state_q    <= bus_state_d;
      slot_q         <= slot_d;
      wait_cnt_q     <= wait_cnt_d;
      stb_vec_q      <= stb_vec_d;
      skip_q         <= (bus_state_q == StResp);
      ack_q          <= ack_d;
      dat_q          <= dat_d;
      to_count_q     <= to_count_d;
      last_to_slot_q <= last_to_slot_d;
      active_q       <= active_d;
      seq_state_q    <= seq_state_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  // Bus next state. The first WAIT cycle only raises the strobe; the counter runs while strobing.
  always_comb begin
    bus_state_d = bus_state_q;
    slot_d      = slot_q;
    wait_cnt_d  = wait_cnt_q;
    unique case (bus_state_q)
      StIdle: begin
        if (accept) begin
          if (in_range && (adr_slot != '0)) begin
            bus_state_d = StWait;
            slot_d      = adr_slot;
            wait_cnt_d  = '0;
          end else begin
            bus_state_d = StResp;
          end
        end
      end
      StWait: begin
        if (strobing) begin
          if (slot_ack_sel || (wait_cnt_q == ToLast)) bus_state_d = StResp;
          else wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StResp:  bus_state_d = StIdle;
      default: bus_state_d = StIdle;
    endcase
  end

  // Registered bus outputs and timeout bookkeeping.
  always_comb begin
    stb_vec_d      = '0;
    ack_d          = (bus_state_d == StResp);
    dat_d          = '0;
    to_count_d     = to_count_q;
    last_to_slot_d = last_to_slot_q;
    if ((bus_state_q == StWait) && (bus_state_d == StWait)) begin
      stb_vec_d = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << slot_q;
    end
    if (accept && is_local && !wbs_we_i) begin
      unique case (offset[7:0])
        8'h00:   dat_d = {24'b0, active_q};
        8'h04:   dat_d = status;
        default: dat_d = '0;
      endcase
    end
    if ((bus_state_q == StWait) && strobing && slot_ack_sel) dat_d = slot_rdata;
    if (timed_out) begin
      dat_d          = 32'hDEAD_0000 | 32'(slot_q);
      to_count_d     = (to_count_q == 8'hFF) ? to_count_q : to_count_q + 8'd1;
      last_to_slot_d = 8'(slot_q);
    end
  end

  // Switchover sequencer; any ACTIVE write during HOLD restarts the hold window.
  always_comb begin
    active_d    = active_q;
    seq_state_d = seq_state_q;
    hold_cnt_d  = hold_cnt_q;
    if (active_wr && ((seq_state_q == StHold) || (wbs_dat_i[7:0] != active_q))) begin
      active_d    = wbs_dat_i[7:0];
      seq_state_d = StHold;
      hold_cnt_d  = HoldInit;
    end else if (seq_state_q == StHold) begin
      if (hold_cnt_q <= 8'd1) seq_state_d = StRun;
      else hold_cnt_d = hold_cnt_q - 8'd1;
    end
  end

  always_comb begin
    wbs_ack_o        = ack_q;
    wbs_dat_o        = dat_q;
    slot_stb_o       = stb_vec_q;
    active_project_o = active_q;
    project_reset_o  = (seq_state_q == StHold);
    io_park_o        = (seq_state_q == StHold);
  end

endmodule
